// File: rtl/reg_scoreboard.sv
// reg_scoreboard: ID-stage register file with a pending-write scoreboard.
// One saturating outstanding-write counter per register drives modi1/modi2;
// register 0 is hardwired to zero and is never pending.
// Optional feature: define SCOREBOARD_WB_BYPASS_EN to forward writeback data
// (and clear the pending flag on the last outstanding write) in the same cycle.
module reg_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0] src1,
    output logic [DATA_WIDTH-1:0] src2,
    output logic                  modi1,
    output logic                  modi2,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic                  issue_stall,
    output logic                  issue_ready,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  flush,
    output logic                  err_underflow
);

    localparam int unsigned NREG = 2 ** ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [DATA_WIDTH-1:0] regs_q [NREG];
    logic [CNT_WIDTH-1:0]  cnt_q  [NREG];
    logic [CNT_WIDTH-1:0]  cnt_d  [NREG];
    logic                  err_q, err_d;

    logic accept;
    logic wb_en;
    logic same_rd;

    // Issue/writeback qualification; register 0 is excluded from both
    always_comb begin
        issue_ready = (cnt_q[issue_rd] != CNT_MAX);
        accept      = issue_valid && !issue_stall && issue_ready && (issue_rd != '0);
        wb_en       = wb_valid && (wb_rd != '0);
        same_rd     = accept && wb_en && (issue_rd == wb_rd);
    end

    // Next counter state: flush clears everything, an issue and writeback to the same register cancel
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q | (wb_en && (cnt_q[wb_rd] == '0));
        if (flush) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                cnt_d[i] = '0;
            end
        end else if (!same_rd) begin
            if (accept) begin
                cnt_d[issue_rd] = cnt_q[issue_rd] + 1'b1;
            end
            if (wb_en && (cnt_q[wb_rd] != '0)) begin
                cnt_d[wb_rd] = cnt_q[wb_rd] - 1'b1;
            end
        end
    end

    // Counter and sticky underflow state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Register data; writes land even in a flush cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en) begin
            regs_q[wb_rd] <= wb_data;
        end
    end

`ifdef SCOREBOARD_WB_BYPASS_EN
    logic byp1, byp2;
    logic last1, last2;

    // Read ports with same-cycle writeback forwarding
    always_comb begin
        byp1  = wb_en && (wb_rd == rs1_addr);
        byp2  = wb_en && (wb_rd == rs2_addr);
        // The flag only drops early when this writeback retires the last pending write
        last1 = byp1 && (cnt_q[rs1_addr] == 1) && !(accept && (issue_rd == rs1_addr));
        last2 = byp2 && (cnt_q[rs2_addr] == 1) && !(accept && (issue_rd == rs2_addr));
        src1  = (rs1_addr == '0) ? '0 : (byp1 ? wb_data : regs_q[rs1_addr]);
        src2  = (rs2_addr == '0) ? '0 : (byp2 ? wb_data : regs_q[rs2_addr]);
        modi1 = (cnt_q[rs1_addr] != '0) && !last1;
        modi2 = (cnt_q[rs2_addr] != '0) && !last2;
    end
`else
    // Read ports straight from registered state
    always_comb begin
        src1  = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
        src2  = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];
        modi1 = (cnt_q[rs1_addr] != '0);
        modi2 = (cnt_q[rs2_addr] != '0);
    end
`endif

    assign err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard-style bench for reg_scoreboard: the driver pushes hand-computed
// expectations per cycle, a monitor on the falling edge pops and compares.
module tb_reg_scoreboard;

`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr, issue_rd, wb_rd;
    logic [31:0] src1, src2, wb_data;
    logic        modi1, modi2, issue_valid, issue_stall, issue_ready;
    logic        wb_valid, flush, err_underflow;

    typedef struct {
        string       name;
        logic [31:0] s1;
        logic [31:0] s2;
        logic        m1;
        logic        m2;
        logic        rdy;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reg_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(2)) dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .src1(src1), .src2(src2), .modi1(modi1), .modi2(modi2),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_stall(issue_stall),
        .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .err_underflow(err_underflow)
    );

    task automatic cmp(input string n, input string f, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%h required=%h", n, f, act, req);
        end
    endtask

    // Monitor: outputs are settled half a cycle after inputs change
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp(e.name, "src1", src1, e.s1);
            cmp(e.name, "src2", src2, e.s2);
            cmp(e.name, "modi1", {31'b0, modi1}, {31'b0, e.m1});
            cmp(e.name, "modi2", {31'b0, modi2}, {31'b0, e.m2});
            cmp(e.name, "issue_ready", {31'b0, issue_ready}, {31'b0, e.rdy});
            cmp(e.name, "err_underflow", {31'b0, err_underflow}, {31'b0, e.err});
        end
    end

    task automatic expect_out(input string n, input logic [31:0] s1, input logic [31:0] s2,
                              input logic m1, input logic m2, input logic rdy, input logic err);
        exp_t e;
        e.name = n; e.s1 = s1; e.s2 = s2; e.m1 = m1; e.m2 = m2; e.rdy = rdy; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        rs1_addr = '0; rs2_addr = '0; issue_valid = 1'b0; issue_rd = '0; issue_stall = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid = 1'b1; issue_rd = rd;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] d);
        wb_valid = 1'b1; wb_rd = rd; wb_data = d;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;

        // Reset state, both while held and after release
        rs1_addr = 5'd5;
        expect_out("reset_hold", 0, 0, 0, 0, 1, 0);
        next();
        rst = 1'b1;
        rs1_addr = 5'd5;
        expect_out("reset_rel", 0, 0, 0, 0, 1, 0);
        next();

        // Issue r3: same-cycle read sees old count, next cycle pending
        issue(5'd3); rs1_addr = 5'd3;
        expect_out("iss3_same", 0, 0, 0, 0, 1, 0);
        next();
        rs1_addr = 5'd3;
        expect_out("iss3_pend", 0, 0, 1, 0, 1, 0);
        next();
        wb(5'd3, 32'hDEADBEEF); rs1_addr = 5'd3;
        expect_out("wb3_cycle", BYP ? 32'hDEADBEEF : 32'h0, 0, !BYP, 0, 1, 0);
        next();
        rs1_addr = 5'd3;
        expect_out("wb3_after", 32'hDEADBEEF, 0, 0, 0, 1, 0);
        next();

        // Saturation on r7
        for (int k = 0; k < 3; k++) begin
            issue(5'd7);
            expect_out("sat_issue", 0, 0, 0, 0, 1, 0);
            next();
        end
        issue(5'd7); rs1_addr = 5'd7;
        expect_out("sat_full", 0, 0, 1, 0, 0, 0);
        next();
        issue_rd = 5'd7; rs1_addr = 5'd7; wb(5'd7, 32'h70);
        expect_out("sat_wb1", BYP ? 32'h70 : 32'h0, 0, 1, 0, 0, 0);
        next();
        issue_rd = 5'd7; rs1_addr = 5'd7; wb(5'd7, 32'h71);
        expect_out("sat_wb2", BYP ? 32'h71 : 32'h70, 0, 1, 0, 1, 0);
        next();
        rs1_addr = 5'd7; wb(5'd7, 32'h72);
        expect_out("sat_wb3", BYP ? 32'h72 : 32'h71, 0, !BYP, 0, 1, 0);
        next();
        issue_rd = 5'd7; rs1_addr = 5'd7;
        expect_out("sat_done", 32'h72, 0, 0, 0, 1, 0);
        next();

        // Stalled issue is not accepted
        issue(5'd4); issue_stall = 1'b1; rs1_addr = 5'd4;
        expect_out("stall_same", 0, 0, 0, 0, 1, 0);
        next();
        rs1_addr = 5'd4;
        expect_out("stall_after", 0, 0, 0, 0, 1, 0);
        next();

        // Register 0 ignores issue and writeback
        issue(5'd0); wb(5'd0, 32'h1);
        expect_out("r0_same", 0, 0, 0, 0, 1, 0);
        next();
        expect_out("r0_after", 0, 0, 0, 0, 1, 0);
        next();

        // Same-cycle issue+wb on r9 with one pending
        issue(5'd9);
        next();
        issue(5'd9); wb(5'd9, 32'h55); rs2_addr = 5'd9;
        expect_out("iw9_same", 0, BYP ? 32'h55 : 32'h0, 0, 1, 1, 0);
        next();
        rs2_addr = 5'd9;
        expect_out("iw9_after", 0, 32'h55, 0, 1, 1, 0);
        next();
        wb(5'd9, 32'h56);
        next();
        rs2_addr = 5'd9;
        expect_out("iw9_clear", 0, 32'h56, 0, 0, 1, 0);
        next();

        // Flush then underflow
        issue(5'd2); next();
        wb(5'd2, 32'h22); next();
        issue(5'd6); next();
        wb(5'd6, 32'h66); next();
        issue(5'd2); next();
        issue(5'd6); next();
        rs1_addr = 5'd2; rs2_addr = 5'd6;
        expect_out("fl_pend", 32'h22, 32'h66, 1, 1, 1, 0);
        next();
        flush = 1'b1; rs1_addr = 5'd2; rs2_addr = 5'd6;
        expect_out("fl_cycle", 32'h22, 32'h66, 1, 1, 1, 0);
        next();
        rs1_addr = 5'd2; rs2_addr = 5'd6;
        expect_out("fl_after", 32'h22, 32'h66, 0, 0, 1, 0);
        next();
        wb(5'd2, 32'h99); rs1_addr = 5'd2;
        expect_out("uf_cycle", BYP ? 32'h99 : 32'h22, 0, 0, 0, 1, 0);
        next();
        rs1_addr = 5'd2;
        expect_out("uf_set", 32'h99, 0, 0, 0, 1, 1);
        next();
        rs1_addr = 5'd2;
        expect_out("uf_sticky", 32'h99, 0, 0, 0, 1, 1);
        next();

        // Mid-operation reset clears everything
        issue(5'd2); next();
        rst = 1'b0; rs1_addr = 5'd2;
        expect_out("rst_mid", 0, 0, 0, 0, 1, 0);
        next();
        rst = 1'b1; rs1_addr = 5'd2;
        expect_out("rst_rel2", 0, 0, 0, 0, 1, 0);
        next();

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Register file with a pending-write scoreboard that sits in the ID stage.
- Produces the operand values (src1_in/src2_in) and the "register being modified" flags (modi1_in/modi2_in) that the ID/EX pipeline register consumes.
- Tracks in-flight destination writes from issue until writeback.
- Its flags drive the ID/EX stall decision.

Parameters:
- DATA_WIDTH, 32, width of register data (matches `COMMON_WIDTH).
- ADDR_WIDTH, 5, register address width (matches `REG_NUM); 2**ADDR_WIDTH registers.
- CNT_WIDTH, 2, width of the per-register outstanding-write counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-low.
- rs1_addr  input  ADDR_WIDTH  source 1 register index.
- rs2_addr  input  ADDR_WIDTH  source 2 register index.
- src1  output  DATA_WIDTH  data of rs1.
- src2  output  DATA_WIDTH  data of rs2.
- modi1  output  1  rs1 has an outstanding write.
- modi2  output  1  rs2 has an outstanding write.
- issue_valid  input  1  instruction with destination issued this cycle.
- issue_rd  input  ADDR_WIDTH  destination of issued instruction.
- issue_stall  input  1  ID/EX block; when high, the issue is not accepted.
- issue_ready  output  1  counter of issue_rd below max; issue may be accepted.
- wb_valid  input  1  writeback this cycle.
- wb_rd  input  ADDR_WIDTH  writeback destination.
- wb_data  input  DATA_WIDTH  writeback data.
- flush  input  1  discard all outstanding writes.
- err_underflow  output  1  sticky: writeback to a register with counter 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers 0, all counters 0, err_underflow 0.
  - So src1=src2=0, modi1=modi2=0, issue_ready=1.
- Storage: 2**ADDR_WIDTH x DATA_WIDTH registers plus one CNT_WIDTH counter per register.
- Register 0:
  - always reads 0, never pending (modi=0).
  - issues and writebacks to it are ignored; no underflow error.
- Issue acceptance:
  - accept = issue_valid & ~issue_stall & issue_ready & issue_rd!=0.
  - On accept, cnt[issue_rd] += 1 at the next edge.
- issue_ready = (cnt[issue_rd] != 2**CNT_WIDTH-1), combinational.
  - An issue_valid with issue_ready=0 is dropped; the counter must never wrap.
- Writeback (wb_valid & wb_rd!=0), next edge:
  - reg[wb_rd] <= wb_data.
  - If cnt>0, cnt[wb_rd] -= 1.
  - If cnt==0, counter stays 0 and err_underflow is set (sticky until reset).
- Simultaneous accepted issue and writeback to the same register: counter unchanged, data written.
- flush:
  - next edge, all counters become 0; register data is not cleared.
  - Flush has priority over issue/writeback counter updates in the same cycle.
  - A writeback in the flush cycle still writes data.
- Read outputs are combinational from state:
  - srcN = reg[rsN]; modiN = (cnt[rsN] != 0).
  - Latency from writeback to visible data/flag clear: 1 cycle (see optional feature).
- Latency from an accepted issue to modi=1 on a read of that register: 1 cycle. The same-cycle read sees the old count.
- rst deassertion mid-operation: state restarts from reset values; no pending writes survive.

Optional Feature:
- Macro: SCOREBOARD_WB_BYPASS_EN.
- Defined:
  - When wb_valid and wb_rd==rsN!=0, srcN = wb_data in the same cycle.
  - modiN is forced 0 in that cycle if cnt[rsN]==1 and no accepted issue to rsN occurs that cycle.
  - Gives 0-cycle writeback-to-read latency.
- Not defined:
  - No bypass; read reflects writeback on the next cycle.
  - modiN stays 1 during the writeback cycle.

Test Plan:
- Reset check: rst=0 then 1, rs1=5, rs2=0 -> src1=0, src2=0, modi1=modi2=0, issue_ready=1, err_underflow=0.
- Issue then writeback:
  - issue r3; next cycle rs1=3 -> modi1=1.
  - wb r3 data 0xDEADBEEF -> next cycle modi1=0, src1=0xDEADBEEF.
  - With bypass: modi1=0 and src1=0xDEADBEEF in the wb cycle.
- Counter saturation (CNT_WIDTH=2):
  - issue r7 three times -> issue_ready=0 for rd=7.
  - 4th issue dropped, so cnt stays 3.
  - three wbs -> modi=0 after the third; no underflow.
- Stall and r0:
  - issue r4 with issue_stall=1 -> rs1=4 modi1=0.
  - issue r0 and wb r0 data 0x1 -> src=0, modi=0, err_underflow=0.
- Same-cycle issue+wb:
  - with cnt[r9]=1, issue r9 and wb r9 data 0x55 in the same cycle.
  - Next cycle cnt=1 (modi=1), src=0x55.
- Flush and underflow:
  - issue r2 and r6; flush -> next cycle modi for both 0, data unchanged.
  - Subsequent wb r2 -> err_underflow=1 and stays 1 until rst.
